// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and widths for the memory-port arbiter
// Contents:
//   ADDR_BITS, LINE_BITS : default address / cache-line widths
//   mem_arb_state_e      : arbiter FSM states
//   mem_owner_e          : which cache owns the in-flight memory transaction
package mem_arbiter_pkg;

  localparam int ADDR_BITS = 32;
  localparam int LINE_BITS = 128;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_WAIT
  } mem_arb_state_e;

  typedef enum logic {
    OWNER_IC,
    OWNER_DC
  } mem_owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - request/response channel between a requester and a memory port
// Signals:
//   req_valid, req_write, req_addr, req_wdata : request, driven by the master
//   req_ready                                 : one-cycle accept, driven by the slave
//   resp_valid, resp_data                     : response, driven by the slave
// Modports: master (issues requests), slave (serves requests).
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_BITS,
  parameter int LINE_WIDTH = LINE_BITS
);

  logic                  req_valid;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [LINE_WIDTH-1:0] req_wdata;
  logic                  req_ready;
  logic                  resp_valid;
  logic [LINE_WIDTH-1:0] resp_data;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_data
  );

endinterface

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational two-way picker between icache and dcache
// Ports:
//   ic_valid, dc_valid : pending requests
//   last_owner         : requester granted most recently (round-robin pointer)
//   winner             : selected requester
//   grant              : a request is pending, winner is meaningful
// Build option MEM_ARB_RR_EN: round-robin on ties; otherwise fixed dcache priority.
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic       ic_valid,
  input  logic       dc_valid,
  input  mem_owner_e last_owner,
  output mem_owner_e winner,
  output logic       grant
);

  assign grant = ic_valid | dc_valid;

`ifdef MEM_ARB_RR_EN
  always_comb begin
    winner = OWNER_DC;
    if (ic_valid && dc_valid) begin
      // On a tie the side not served last goes next.
      winner = (last_owner == OWNER_DC) ? OWNER_IC : OWNER_DC;
    end else if (ic_valid) begin
      winner = OWNER_IC;
    end
  end
`else
  // Fixed priority: a dcache stall freezes the whole pipeline.
  mem_owner_e unused_last_owner;
  assign unused_last_owner = last_owner;
  assign winner = dc_valid ? OWNER_DC : OWNER_IC;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares the single main-memory port between icache and dcache
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   ic    : icache line-read channel (slave); write/wdata of this channel are not used
//   dc    : dcache fill / write-back channel (slave)
//   mem   : main-memory channel (master)
// One transaction outstanding at a time; the response is routed to the owner
// one cycle after the memory response and is 0 on the other side.
// Build option MEM_ARB_RR_EN: round-robin tie-break instead of fixed dcache priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_BITS,
  parameter int LINE_WIDTH = LINE_BITS
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave  ic,
  mem_arbiter_if.slave  dc,
  mem_arbiter_if.master mem
);

  mem_arb_state_e        state_q, state_d;
  mem_owner_e            owner_q;
  mem_owner_e            last_owner;
  mem_owner_e            winner;
  logic                  grant;
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic                  ic_resp_q, dc_resp_q;
  logic [LINE_WIDTH-1:0] resp_data_q;
  logic                  take_grant;
  logic                  take_resp;

  mem_arb_pick u_pick (
    .ic_valid   (ic.req_valid),
    .dc_valid   (dc.req_valid),
    .last_owner (last_owner),
    .winner     (winner),
    .grant      (grant)
  );

  assign take_grant = (state_q == ARB_IDLE) && grant;
  // Responses outside ARB_WAIT are spurious and dropped.
  assign take_resp  = (state_q == ARB_WAIT) && mem.resp_valid;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ARB_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: if (grant)          state_d = ARB_REQ;
      ARB_REQ:  if (mem.req_ready)  state_d = ARB_WAIT;
      ARB_WAIT: if (mem.resp_valid) state_d = ARB_IDLE;
      default:                      state_d = ARB_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    ic.req_ready  = take_grant && (winner == OWNER_IC);
    dc.req_ready  = take_grant && (winner == OWNER_DC);
    mem.req_valid = (state_q == ARB_REQ);
    mem.req_write = write_q;
    mem.req_addr  = addr_q;
    mem.req_wdata = wdata_q;
    ic.resp_valid = ic_resp_q;
    dc.resp_valid = dc_resp_q;
    ic.resp_data  = ic_resp_q ? resp_data_q : '0;
    dc.resp_data  = dc_resp_q ? resp_data_q : '0;
  end

  // Request latch and registered response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q     <= OWNER_IC;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ic_resp_q   <= 1'b0;
      dc_resp_q   <= 1'b0;
      resp_data_q <= '0;
    end else begin
      if (take_grant) begin
        owner_q <= winner;
        if (winner == OWNER_DC) begin
          write_q <= dc.req_write;
          addr_q  <= dc.req_addr;
          wdata_q <= dc.req_wdata;
        end else begin
          write_q <= 1'b0;
          addr_q  <= ic.req_addr;
          wdata_q <= '0;
        end
      end
      ic_resp_q <= take_resp && (owner_q == OWNER_IC);
      dc_resp_q <= take_resp && (owner_q == OWNER_DC);
      if (take_resp) begin
        // A write ack carries no data.
        resp_data_q <= write_q ? '0 : mem.resp_data;
      end
    end
  end

`ifdef MEM_ARB_RR_EN
  // Round-robin pointer: reset to icache-last so the first tie goes to dcache.
  mem_owner_e last_owner_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           last_owner_q <= OWNER_IC;
    else if (take_grant) last_owner_q <= winner;
  end
  assign last_owner = last_owner_q;
`else
  assign last_owner = OWNER_IC;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mem_arbiter_if ic_if ();
  mem_arbiter_if dc_if ();
  mem_arbiter_if mem_if ();

  mem_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .ic    (ic_if),
    .dc    (dc_if),
    .mem   (mem_if)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] D_LONE = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
  localparam logic [127:0] D_IC   = 128'h11112222_33334444_55556666_77778888;
  localparam logic [127:0] D_DC   = 128'hC0DEC0DE_0000FFFF_12345678_9ABCDEF0;
  localparam logic [127:0] D_WB   = {16{8'hA5}};
  localparam logic [127:0] D_SIX  = 128'h66666666_00000000_66666666_00000006;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ic_ready"}, ic_if.req_ready, 1'b0);
    chk({tag, "_dc_ready"}, dc_if.req_ready, 1'b0);
    chk({tag, "_ic_resp"}, ic_if.resp_valid, 1'b0);
    chk({tag, "_dc_resp"}, dc_if.resp_valid, 1'b0);
    chk({tag, "_ic_rdata"}, ic_if.resp_data, '0);
    chk({tag, "_dc_rdata"}, dc_if.resp_data, '0);
    chk({tag, "_mem_valid"}, mem_if.req_valid, 1'b0);
    chk({tag, "_mem_write"}, mem_if.req_write, 1'b0);
    chk({tag, "_mem_addr"}, mem_if.req_addr, '0);
    chk({tag, "_mem_wdata"}, mem_if.req_wdata, '0);
  endtask

  initial begin
    bit [3:0] exp_dc;
    int       ic_left;
    int       dc_left;
    bit       prev_dc;

    reset = 1'b1;
    ic_if.req_valid = 1'b0; ic_if.req_write = 1'b0; ic_if.req_addr = '0; ic_if.req_wdata = '0;
    dc_if.req_valid = 1'b0; dc_if.req_write = 1'b0; dc_if.req_addr = '0; dc_if.req_wdata = '0;
    mem_if.req_ready = 1'b0; mem_if.resp_valid = 1'b0; mem_if.resp_data = '0;

    repeat (2) @(negedge clk);
    #1 chk_idle_outputs("reset");
    @(negedge clk); reset = 1'b0;

    // Lone icache read of 0x100, memory ready at once, response two cycles after acceptance
    @(negedge clk); ic_if.req_valid = 1'b1; ic_if.req_addr = 32'h100; mem_if.req_ready = 1'b1;
    #1 chk("lone_ic_ready", ic_if.req_ready, 1'b1);
    chk("lone_dc_ready", dc_if.req_ready, 1'b0);
    @(negedge clk); ic_if.req_valid = 1'b0;
    #1 chk("lone_mem_valid", mem_if.req_valid, 1'b1);
    chk("lone_mem_addr", mem_if.req_addr, 32'h100);
    chk("lone_mem_write", mem_if.req_write, 1'b0);
    @(negedge clk);
    #1 chk("lone_wait_valid", mem_if.req_valid, 1'b0);
    @(negedge clk); mem_if.resp_valid = 1'b1; mem_if.resp_data = D_LONE;
    #1 chk("lone_early_resp", ic_if.resp_valid, 1'b0);
    @(negedge clk); mem_if.resp_valid = 1'b0;
    #1 chk("lone_ic_resp", ic_if.resp_valid, 1'b1);
    chk("lone_ic_data", ic_if.resp_data, D_LONE);
    chk("lone_dc_resp", dc_if.resp_valid, 1'b0);
    @(negedge clk);
    #1 chk("lone_resp_pulse_end", ic_if.resp_valid, 1'b0);

    // Two icache (0x200) and two dcache (0x300) reads presented together
`ifdef MEM_ARB_RR_EN
    exp_dc = 4'b0101;
`else
    exp_dc = 4'b0011;
`endif
    ic_left = 2; dc_left = 2; prev_dc = 1'b0;
    ic_if.req_addr = 32'h200; dc_if.req_addr = 32'h300; dc_if.req_write = 1'b0;
    for (int g = 0; g < 4; g++) begin
      @(negedge clk);
      mem_if.resp_valid = 1'b0;
      ic_if.req_valid = (ic_left > 0); dc_if.req_valid = (dc_left > 0);
      #1 chk("tie_dc_ready", dc_if.req_ready, exp_dc[g]);
      chk("tie_ic_ready", ic_if.req_ready, !exp_dc[g]);
      if (g > 0) begin
        chk("tie_prev_dc_resp", dc_if.resp_valid, prev_dc);
        chk("tie_prev_ic_resp", ic_if.resp_valid, !prev_dc);
        chk("tie_prev_data", prev_dc ? dc_if.resp_data : ic_if.resp_data, prev_dc ? D_DC : D_IC);
      end
      if (exp_dc[g]) dc_left--; else ic_left--;
      prev_dc = exp_dc[g];
      @(negedge clk);
      ic_if.req_valid = (ic_left > 0); dc_if.req_valid = (dc_left > 0);
      #1 chk("tie_mem_valid", mem_if.req_valid, 1'b1);
      chk("tie_mem_addr", mem_if.req_addr, prev_dc ? 32'h300 : 32'h200);
      chk("tie_mem_write", mem_if.req_write, 1'b0);
      chk("tie_req_ic_ready", ic_if.req_ready, 1'b0);
      chk("tie_req_dc_ready", dc_if.req_ready, 1'b0);
      @(negedge clk);
      mem_if.resp_valid = 1'b1; mem_if.resp_data = prev_dc ? D_DC : D_IC;
      #1 chk("tie_wait_ic_ready", ic_if.req_ready, 1'b0);
      chk("tie_wait_dc_ready", dc_if.req_ready, 1'b0);
      chk("tie_wait_ic_resp", ic_if.resp_valid, 1'b0);
      chk("tie_wait_dc_resp", dc_if.resp_valid, 1'b0);
    end
    @(negedge clk);
    mem_if.resp_valid = 1'b0; ic_if.req_valid = 1'b0; dc_if.req_valid = 1'b0;
    #1 chk("tie_last_ic_resp", ic_if.resp_valid, 1'b1);
    chk("tie_last_ic_data", ic_if.resp_data, D_IC);
    chk("tie_last_dc_resp", dc_if.resp_valid, 1'b0);

    // dcache write-back of 0x400 with memory stalling for three cycles
    @(negedge clk);
    mem_if.req_ready = 1'b0;
    dc_if.req_valid = 1'b1; dc_if.req_write = 1'b1; dc_if.req_addr = 32'h400; dc_if.req_wdata = D_WB;
    #1 chk("wb_dc_ready", dc_if.req_ready, 1'b1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      dc_if.req_valid = 1'b0; dc_if.req_write = 1'b0; dc_if.req_addr = '0; dc_if.req_wdata = '0;
      mem_if.req_ready = (c == 3);
      #1 chk("wb_mem_valid", mem_if.req_valid, 1'b1);
      chk("wb_mem_addr", mem_if.req_addr, 32'h400);
      chk("wb_mem_wdata", mem_if.req_wdata, D_WB);
      chk("wb_mem_write", mem_if.req_write, 1'b1);
    end
    @(negedge clk);
    mem_if.req_ready = 1'b0; mem_if.resp_valid = 1'b1; mem_if.resp_data = '1;
    #1 chk("wb_wait_valid", mem_if.req_valid, 1'b0);
    @(negedge clk); mem_if.resp_valid = 1'b0;
    #1 chk("wb_ack_valid", dc_if.resp_valid, 1'b1);
    chk("wb_ack_data", dc_if.resp_data, '0);
    chk("wb_ack_ic_resp", ic_if.resp_valid, 1'b0);

    // Spurious response in ARB_IDLE, then an icache request still granted at once
    @(negedge clk); mem_if.resp_valid = 1'b1; mem_if.resp_data = 128'hBAD;
    #1 chk("spur_mem_valid", mem_if.req_valid, 1'b0);
    @(negedge clk);
    mem_if.resp_valid = 1'b0; ic_if.req_valid = 1'b1; ic_if.req_addr = 32'h500;
    #1 chk("spur_ic_resp", ic_if.resp_valid, 1'b0);
    chk("spur_dc_resp", dc_if.resp_valid, 1'b0);
    chk("spur_ic_ready", ic_if.req_ready, 1'b1);
    @(negedge clk); ic_if.req_valid = 1'b0; mem_if.req_ready = 1'b1;
    #1 chk("pre_rst_mem_addr", mem_if.req_addr, 32'h500);

    // Reset while in ARB_WAIT; the late memory response must be dropped
    @(negedge clk); mem_if.req_ready = 1'b0; reset = 1'b1;
    #1 chk_idle_outputs("rst_wait");
    @(negedge clk); reset = 1'b0; mem_if.resp_valid = 1'b1; mem_if.resp_data = D_LONE;
    #1 chk("post_rst_mem_valid", mem_if.req_valid, 1'b0);
    @(negedge clk); mem_if.resp_valid = 1'b0;
    #1 chk("post_rst_ic_resp", ic_if.resp_valid, 1'b0);
    chk("post_rst_dc_resp", dc_if.resp_valid, 1'b0);

    // Normal dcache read of 0x600 after reset
    @(negedge clk); dc_if.req_valid = 1'b1; dc_if.req_write = 1'b0; dc_if.req_addr = 32'h600;
    mem_if.req_ready = 1'b1;
    #1 chk("after_rst_dc_ready", dc_if.req_ready, 1'b1);
    @(negedge clk); dc_if.req_valid = 1'b0;
    #1 chk("after_rst_mem_valid", mem_if.req_valid, 1'b1);
    chk("after_rst_mem_addr", mem_if.req_addr, 32'h600);
    @(negedge clk); mem_if.resp_valid = 1'b1; mem_if.resp_data = D_SIX;
    #1 chk("after_rst_no_early", dc_if.resp_valid, 1'b0);
    @(negedge clk); mem_if.resp_valid = 1'b0;
    #1 chk("after_rst_dc_resp", dc_if.resp_valid, 1'b1);
    chk("after_rst_dc_data", dc_if.resp_data, D_SIX);
    chk("after_rst_ic_resp", ic_if.resp_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
